// File: rtl/store_buffer.sv
// Post-commit store buffer: a circular FIFO that holds executed stores until the ROB
// grants permission, drains them in order to the D-cache and forwards data to loads.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module store_buffer #(
  parameter int N               = 4,
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [WORD_SIZE-1:0]       st_addr,
  input  logic [WORD_SIZE-1:0]       st_data,
  input  logic                       st_is_byte,
  input  logic [ROB_ENTRY_WIDTH-1:0] st_rob_id,
  output logic                       full,
  input  logic                       sb_store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id,
  input  logic                       flush,
  input  logic [WORD_SIZE-1:0]       ld_addr,
  output logic                       fwd_hit,
  output logic [WORD_SIZE-1:0]       fwd_data,
  output logic                       fwd_stall,
  output logic                       dc_req_valid,
  input  logic                       dc_req_ready,
  output logic [WORD_SIZE-1:0]       dc_addr,
  output logic [WORD_SIZE-1:0]       dc_data,
  output logic                       dc_is_byte
);

  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [N-1:0]  valid;
  logic [N-1:0]  committed;

  logic [WORD_SIZE-1:0]       entry_addr   [N];
  logic [WORD_SIZE-1:0]       entry_data   [N];
  logic                       entry_byte   [N];
  logic [ROB_ENTRY_WIDTH-1:0] entry_rob_id [N];

  logic          alloc;
  logic          drain;
  logic [CW-1:0] commit_cnt;
  logic [PW-1:0] idx;

  // full is evaluated on pre-edge state, so a concurrent drain never frees a slot early.
  assign full         = (count == CW'(N));
  assign alloc        = st_valid && !full && !flush;
  assign dc_req_valid = valid[head] && committed[head];
  assign drain        = dc_req_valid && dc_req_ready;
  assign dc_addr      = entry_addr[head];
  assign dc_data      = entry_data[head];
  assign dc_is_byte   = entry_byte[head];

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    commit_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && committed[i]) commit_cnt = commit_cnt + CW'(1);
    end
  end

  // Walk oldest to youngest; the last match seen is the youngest store.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && entry_addr[idx][WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2]) begin
        fwd_hit   = !entry_byte[idx];
        fwd_stall = entry_byte[idx];
        fwd_data  = entry_byte[idx] ? '0 : entry_data[idx];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; later writes in the block win.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      valid     <= '0;
      committed <= '0;
    end else begin
      if (flush) begin
        // Committed entries form a prefix from head, so they survive and tail snaps after them.
        valid <= valid & committed;
        tail  <= head + commit_cnt[PW-1:0];
        count <= commit_cnt - CW'(drain);
      end else begin
        for (int i = 0; i < N; i++) begin
          if (sb_store_permission && valid[i] && !committed[i] && entry_rob_id[i] == sb_rob_id)
            committed[i] <= 1'b1;
        end
        if (alloc) begin
          valid[tail]     <= 1'b1;
          committed[tail] <= 1'b0;
          tail            <= tail + PW'(1);
        end
        count <= count + CW'(alloc) - CW'(drain);
      end
      if (drain) begin
        valid[head]     <= 1'b0;
        committed[head] <= 1'b0;
        head            <= head + PW'(1);
      end
    end
  end

  // NOTE: payload storage is not reset; valid bits alone decide whether an entry is live.
  always_ff @(posedge clk) begin
    if (alloc) begin
      entry_addr[tail]   <= st_addr;
      entry_data[tail]   <= st_data;
      entry_byte[tail]   <= st_is_byte;
      entry_rob_id[tail] <= st_rob_id;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, corner-case sequences,
// then randomized traffic compared against a queue-based model of the buffer.
module tb_store_buffer;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [W-1:0]  st_addr;
  logic [W-1:0]  st_data;
  logic          st_is_byte;
  logic [RW-1:0] st_rob_id;
  logic          full;
  logic          sb_store_permission;
  logic [RW-1:0] sb_rob_id;
  logic          flush;
  logic [W-1:0]  ld_addr;
  logic          fwd_hit;
  logic [W-1:0]  fwd_data;
  logic          fwd_stall;
  logic          dc_req_valid;
  logic          dc_req_ready;
  logic [W-1:0]  dc_addr;
  logic [W-1:0]  dc_data;
  logic          dc_is_byte;

  always #5 clk = ~clk;

  store_buffer #(.N(N), .WORD_SIZE(W), .ROB_ENTRY_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_is_byte(st_is_byte), .st_rob_id(st_rob_id), .full(full),
    .sb_store_permission(sb_store_permission), .sb_rob_id(sb_rob_id),
    .flush(flush), .ld_addr(ld_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_addr(dc_addr), .dc_data(dc_data), .dc_is_byte(dc_is_byte)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    st_valid            = 1'b0;
    sb_store_permission = 1'b0;
    flush               = 1'b0;
    dc_req_ready        = 1'b0;
  endtask

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] d, input logic b, input logic [RW-1:0] r);
    st_valid   = 1'b1;
    st_addr    = a;
    st_data    = d;
    st_is_byte = b;
    st_rob_id  = r;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One row = inputs for one edge, then expected outputs once control inputs drop.
  typedef struct {
    logic          st_v;
    logic [W-1:0]  a;
    logic [W-1:0]  d;
    logic          b;
    logic [RW-1:0] rob;
    logic          perm;
    logic [RW-1:0] prob;
    logic          fl;
    logic          rdy;
    logic [W-1:0]  ld;
    logic          e_full;
    logic          e_dcv;
    logic [W-1:0]  e_dca;
    logic          e_hit;
    logic          e_stall;
    logic [W-1:0]  e_fd;
    logic [2:0]    e_cnt;
  } vec_t;

  typedef struct {
    logic [W-1:0]  addr;
    logic [W-1:0]  data;
    logic          is_byte;
    logic [RW-1:0] rob;
    logic          committed;
  } ent_t;

  vec_t vec[11];
  ent_t q[$];

  initial begin
    logic [W-1:0]  hold_addr;
    logic [W-1:0]  hold_data;
    logic [RW-1:0] next_rob;
    int            first_unc;
    int            match_j;
    logic          m_full, m_dcv, m_hit, m_stall, m_drain, m_acc;
    logic [W-1:0]  m_fd;
    ent_t          e;

    st_addr = '0; st_data = '0; st_is_byte = 1'b0; st_rob_id = '0;
    sb_rob_id = '0; ld_addr = '0;
    clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_full", full, 0);
    check("reset_dcv", dc_req_valid, 0);
    check("reset_hit", fwd_hit, 0);
    check("reset_stall", fwd_stall, 0);
    check("reset_count", dut.count, 0);

    // st_v a d b rob perm prob fl rdy ld | full dcv dca hit stall fd cnt
    vec[0]  = '{1, 32'h200, 32'h11, 0, 4'd1, 0, 4'd0, 0, 0, 32'h200, 0, 0, 32'h0,   1, 0, 32'h11, 3'd1};
    vec[1]  = '{1, 32'h201, 32'h22, 1, 4'd2, 0, 4'd0, 0, 0, 32'h200, 0, 0, 32'h0,   0, 1, 32'h0,  3'd2};
    vec[2]  = '{1, 32'h200, 32'h33, 0, 4'd3, 0, 4'd0, 0, 0, 32'h200, 0, 0, 32'h0,   1, 0, 32'h33, 3'd3};
    vec[3]  = '{0, 32'h0,   32'h0,  0, 4'd0, 0, 4'd0, 0, 0, 32'h300, 0, 0, 32'h0,   0, 0, 32'h0,  3'd3};
    vec[4]  = '{1, 32'h300, 32'h44, 0, 4'd4, 0, 4'd0, 0, 0, 32'h300, 1, 0, 32'h0,   1, 0, 32'h44, 3'd4};
    vec[5]  = '{1, 32'h400, 32'h99, 0, 4'd5, 0, 4'd0, 0, 0, 32'h400, 1, 0, 32'h0,   0, 0, 32'h0,  3'd4};
    vec[6]  = '{0, 32'h0,   32'h0,  0, 4'd0, 1, 4'd1, 0, 0, 32'h400, 1, 1, 32'h200, 0, 0, 32'h0,  3'd4};
    vec[7]  = '{1, 32'h500, 32'h55, 0, 4'd6, 0, 4'd0, 0, 1, 32'h500, 0, 0, 32'h0,   0, 0, 32'h0,  3'd3};
    vec[8]  = '{1, 32'h500, 32'h55, 0, 4'd6, 0, 4'd0, 0, 0, 32'h500, 1, 0, 32'h0,   1, 0, 32'h55, 3'd4};
    vec[9]  = '{0, 32'h0,   32'h0,  0, 4'd0, 0, 4'd0, 1, 0, 32'h500, 0, 0, 32'h0,   0, 0, 32'h0,  3'd0};
    vec[10] = '{0, 32'h0,   32'h0,  0, 4'd0, 1, 4'd2, 0, 0, 32'h200, 0, 0, 32'h0,   0, 0, 32'h0,  3'd0};

    for (int i = 0; i < 11; i++) begin
      st_valid = vec[i].st_v; st_addr = vec[i].a; st_data = vec[i].d;
      st_is_byte = vec[i].b; st_rob_id = vec[i].rob;
      sb_store_permission = vec[i].perm; sb_rob_id = vec[i].prob;
      flush = vec[i].fl; dc_req_ready = vec[i].rdy; ld_addr = vec[i].ld;
      tick();
      clr();
      #1;
      check($sformatf("vec%0d_full", i), full, vec[i].e_full);
      check($sformatf("vec%0d_dcv", i), dc_req_valid, vec[i].e_dcv);
      if (vec[i].e_dcv) check($sformatf("vec%0d_dc_addr", i), dc_addr, vec[i].e_dca);
      check($sformatf("vec%0d_hit", i), fwd_hit, vec[i].e_hit);
      check($sformatf("vec%0d_stall", i), fwd_stall, vec[i].e_stall);
      check($sformatf("vec%0d_fwd_data", i), fwd_data, vec[i].e_fd);
      check($sformatf("vec%0d_count", i), dut.count, vec[i].e_cnt);
    end

    // Basic commit and drain: request appears one cycle after permission.
    do_reset();
    put(32'h100, 32'hDEADBEEF, 0, 4'd3);
    tick(); clr();
    check("sw_count1", dut.count, 1);
    check("sw_dcv_before_perm", dc_req_valid, 0);
    sb_store_permission = 1; sb_rob_id = 4'd3; dc_req_ready = 1;
    tick(); sb_store_permission = 0;
    check("sw_dcv_after_perm", dc_req_valid, 1);
    check("sw_dc_addr", dc_addr, 32'h100);
    check("sw_dc_data", dc_data, 32'hDEADBEEF);
    check("sw_dc_is_byte", dc_is_byte, 0);
    tick(); clr();
    check("sw_dcv_drained", dc_req_valid, 0);
    check("sw_count0", dut.count, 0);

    // Permission in the allocation cycle must not commit the new entry.
    put(32'h40, 32'h77, 0, 4'd5);
    sb_store_permission = 1; sb_rob_id = 4'd5;
    tick(); clr();
    check("same_cycle_perm_dcv", dc_req_valid, 0);
    sb_store_permission = 1; sb_rob_id = 4'd5;
    tick(); clr();
    check("late_perm_dcv", dc_req_valid, 1);
    dc_req_ready = 1;
    tick(); clr();
    check("late_perm_drained", dut.count, 0);

    // Flush keeps the committed head, drops the rest and blocks a concurrent store.
    do_reset();
    put(32'h10, 32'hA1, 0, 4'd7); tick();
    put(32'h20, 32'hA2, 0, 4'd8); tick();
    put(32'h30, 32'hA3, 0, 4'd9); tick(); clr();
    sb_store_permission = 1; sb_rob_id = 4'd7;
    tick(); clr();
    check("fl_pre_dcv", dc_req_valid, 1);
    check("fl_pre_count", dut.count, 3);
    flush = 1; put(32'h50, 32'hA5, 0, 4'd10);
    tick(); clr();
    check("fl_count", dut.count, 1);
    check("fl_dcv", dc_req_valid, 1);
    check("fl_dc_addr", dc_addr, 32'h10);
    ld_addr = 32'h20; #1;
    check("fl_ld_dropped_hit", fwd_hit, 0);
    check("fl_ld_dropped_stall", fwd_stall, 0);
    ld_addr = 32'h50; #1;
    check("fl_ld_blocked_hit", fwd_hit, 0);
    ld_addr = 32'h10; #1;
    check("fl_ld_kept_hit", fwd_hit, 1);
    check("fl_ld_kept_data", fwd_data, 32'hA1);
    dc_req_ready = 1;
    tick(); clr();
    check("fl_drain_count", dut.count, 0);
    check("fl_drain_dcv", dc_req_valid, 0);
    put(32'h60, 32'hB1, 0, 4'd11); tick();
    put(32'h70, 32'hB2, 0, 4'd12); sb_store_permission = 1; sb_rob_id = 4'd11;
    tick(); clr();
    check("fl2_count", dut.count, 2);
    flush = 1; dc_req_ready = 1;
    tick(); clr();
    check("fl2_drain_count", dut.count, 0);
    check("fl2_drain_dcv", dc_req_valid, 0);
    put(32'h80, 32'hB3, 0, 4'd13); ld_addr = 32'h80;
    tick(); clr(); #1;
    check("fl2_realloc_count", dut.count, 1);
    check("fl2_realloc_hit", fwd_hit, 1);
    check("fl2_realloc_data", fwd_data, 32'hB3);

    // Back-pressure: head fields hold while ready is low; reset aborts the drain.
    do_reset();
    put(32'h300, 32'hCAFEF00D, 1, 4'd2); tick(); clr();
    sb_store_permission = 1; sb_rob_id = 4'd2;
    tick(); clr();
    hold_addr = 32'h300; hold_data = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) put(32'h304, 32'h12, 0, 4'd3);
      tick(); clr();
      check($sformatf("hold%0d_dcv", c), dc_req_valid, 1);
      check($sformatf("hold%0d_addr", c), dc_addr, hold_addr);
      check($sformatf("hold%0d_data", c), dc_data, hold_data);
      check($sformatf("hold%0d_byte", c), dc_is_byte, 1);
    end
    rst = 1; dc_req_ready = 1; ld_addr = 32'h304;
    tick(); rst = 0; clr(); #1;
    check("rst_hold_dcv", dc_req_valid, 0);
    check("rst_hold_count", dut.count, 0);
    check("rst_hold_full", full, 0);
    check("rst_hold_hit", fwd_hit, 0);

    // Randomized traffic against a queue model (index 0 = oldest).
    do_reset();
    q.delete();
    next_rob = '0;
    for (int c = 0; c < 1500; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      st_valid     = $urandom_range(0, 1);
      st_addr      = 32'h1000 + $urandom_range(0, 15);
      st_data      = $urandom;
      st_is_byte   = $urandom_range(0, 1);
      st_rob_id    = next_rob;
      flush        = ($urandom_range(0, 29) == 0);
      dc_req_ready = ($urandom_range(0, 9) < 6);
      ld_addr      = 32'h1000 + $urandom_range(0, 15);
      first_unc = -1;
      for (int j = 0; j < q.size(); j++)
        if (first_unc < 0 && !q[j].committed) first_unc = j;
      if (first_unc >= 0 && $urandom_range(0, 9) < 4) begin
        sb_store_permission = 1; sb_rob_id = q[first_unc].rob;
      end else if ($urandom_range(0, 9) == 0) begin
        sb_store_permission = 1; sb_rob_id = next_rob + RW'(8);
      end else begin
        sb_store_permission = 0;
      end
      #1;

      m_full  = (q.size() == N);
      m_dcv   = (q.size() > 0) && q[0].committed;
      match_j = -1;
      for (int j = q.size() - 1; j >= 0; j--)
        if (match_j < 0 && (q[j].addr >> 2) == (ld_addr >> 2)) match_j = j;
      m_hit   = (match_j >= 0) && !q[match_j].is_byte;
      m_stall = (match_j >= 0) && q[match_j].is_byte;
      m_fd    = m_hit ? q[match_j].data : '0;
      check("rnd_full", full, m_full);
      check("rnd_dcv", dc_req_valid, m_dcv);
      if (m_dcv) begin
        check("rnd_dc_addr", dc_addr, q[0].addr);
        check("rnd_dc_data", dc_data, q[0].data);
        check("rnd_dc_byte", dc_is_byte, q[0].is_byte);
      end
      check("rnd_hit", fwd_hit, m_hit);
      check("rnd_stall", fwd_stall, m_stall);
      check("rnd_fwd_data", fwd_data, m_fd);
      check("rnd_count", dut.count, q.size());

      if (rst) begin
        q.delete();
      end else begin
        m_drain = m_dcv && dc_req_ready;
        if (flush) begin
          while (q.size() > 0 && !q[q.size()-1].committed) void'(q.pop_back());
          if (m_drain) void'(q.pop_front());
        end else begin
          m_acc = st_valid && (q.size() < N);
          if (sb_store_permission) begin
            match_j = -1;
            for (int j = 0; j < q.size(); j++)
              if (match_j < 0 && !q[j].committed && q[j].rob == sb_rob_id) match_j = j;
            if (match_j >= 0) q[match_j].committed = 1'b1;
          end
          if (m_drain) void'(q.pop_front());
          if (m_acc) begin
            e.addr = st_addr; e.data = st_data; e.is_byte = st_is_byte;
            e.rob = st_rob_id; e.committed = 1'b0;
            q.push_back(e);
            next_rob = next_rob + RW'(1);
          end
        end
      end
      tick();
    end
    clr();
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter N, 4, number of store buffer entries (power of two).
REQ-002 Parameter WORD_SIZE, 32, data/address width.
REQ-003 Parameter ROB_ENTRY_WIDTH, `ROB_ENTRY_WIDTH, ROB tag width.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 st_valid  in  1  MEM stage presents an executed store.
REQ-007 st_addr  in  WORD_SIZE  physical store address.
REQ-008 st_data  in  WORD_SIZE  store data (byte stores use bits [7:0]).
REQ-009 st_is_byte  in  1  1 = SB, 0 = SW.
REQ-010 st_rob_id  in  ROB_ENTRY_WIDTH  ROB tag of the store.
REQ-011 full  out  1  no free entry; MEM stage stalls.
REQ-012 sb_store_permission  in  1  ROB head is a ready, exception-free store.
REQ-013 sb_rob_id  in  ROB_ENTRY_WIDTH  ROB tag granted permission.
REQ-014 flush  in  1  exception flush; drop all uncommitted stores.
REQ-015 ld_addr  in  WORD_SIZE  load address for forwarding lookup.
REQ-016 fwd_hit  out  1  youngest matching entry is a word store; fwd_data valid.
REQ-017 fwd_data  out  WORD_SIZE  forwarded store data.
REQ-018 fwd_stall  out  1  youngest match is a byte store; load must stall.
REQ-019 dc_req_valid  out  1  drain request to D-cache.
REQ-020 dc_req_ready  in  1  D-cache accepts the request this cycle.
REQ-021 dc_addr / dc_data / dc_is_byte  out  WORD_SIZE / WORD_SIZE / 1  head entry fields.

Function
REQ-022 Storage SHALL be a circular FIFO: head, tail ($clog2(N) bits, wrap modulo N), count ($clog2(N)+1 bits); per entry valid, committed, addr, data, is_byte, rob_id.
REQ-023 full SHALL be combinational: count == N.
REQ-024 st_valid && !full SHALL write the entry at tail (committed=0), tail+1, count+1; st_valid while full SHALL be ignored.
REQ-025 sb_store_permission SHALL set committed on the single valid, uncommitted entry whose rob_id == sb_rob_id; no match SHALL be a no-op.
REQ-026 Permission SHALL only match entries valid before the edge; an entry allocated in the same cycle SHALL NOT be committed that cycle.
REQ-027 dc_req_valid SHALL equal valid[head] && committed[head]; dc_addr/dc_data/dc_is_byte SHALL reflect head fields combinationally and stay stable while valid && !ready.
REQ-028 dc_req_valid && dc_req_ready SHALL clear head entry, head+1, count-1 (one drain per cycle, latency from commit to first request = 1 cycle).
REQ-029 Simultaneous allocate and drain SHALL leave count unchanged; allocate at full with concurrent drain SHALL still be refused (full is pre-edge).
REQ-030 Forwarding SHALL compare ld_addr[WORD_SIZE-1:2] with every valid entry's addr[WORD_SIZE-1:2] and select the youngest (closest to tail) match.
REQ-031 Youngest match word store -> fwd_hit=1, fwd_data=data, fwd_stall=0; byte store -> fwd_hit=0, fwd_stall=1; no match -> both 0, fwd_data=0.
REQ-032 flush SHALL invalidate all uncommitted entries and set tail = head + committed count, count = committed count; committed entries SHALL continue draining.
REQ-033 flush SHALL take priority over st_valid in the same cycle (no allocation); a concurrent drain SHALL still complete.
REQ-034 Committed entries SHALL always be contiguous from head (ROB commits in order).

Reset
REQ-035 rst SHALL clear head, tail, count, all valid and committed bits; full, fwd_hit, fwd_stall, dc_req_valid SHALL be 0 the cycle after.
REQ-036 rst SHALL override all other inputs in the same cycle, including an in-flight drain.

Verification
REQ-037 SW 0x100/0xDEADBEEF rob 3, permission rob 3 next cycle, ready=1 -> dc_req_valid 1 cycle after permission, addr 0x100, count returns 0.
REQ-038 Four stores, no permission -> full=1; fifth st_valid ignored; one permission+drain -> full=0, wrap tail reallocates slot 0.
REQ-039 SW 0x200=0x11, SB 0x201=0x22, ld_addr 0x200 -> fwd_stall=1; SW 0x200=0x33 younger -> fwd_hit=1, fwd_data=0x33.
REQ-040 Three stores, first committed, flush -> count=1, only first drains, later ld_addr match on flushed entries -> no hit.
REQ-041 dc_req_ready low 3 cycles -> dc_req_valid and dc fields stable; rst mid-hold -> dc_req_valid=0, count=0.
